// File: rtl/rv_ctrl_pkg.sv
// Shared types for the pipelined RV32I control unit: opcodes, control enums and the per-stage control bundle.
// Optional macro RV_M_EXT_EN (consumed by rv_decoder) enables the M-extension encodings.
package rv_ctrl_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int ALU_OP_W   = 5;
    localparam int IMM_SEL_W  = 3;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [IMM_SEL_W-1:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_sel_e;

    // Base ops are {alt, funct3} so OP/OP-IMM map directly; M ops sit at 16+funct3.
    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD    = 5'd0,
        ALU_SLL    = 5'd1,
        ALU_SLT    = 5'd2,
        ALU_SLTU   = 5'd3,
        ALU_XOR    = 5'd4,
        ALU_SRL    = 5'd5,
        ALU_OR     = 5'd6,
        ALU_AND    = 5'd7,
        ALU_SUB    = 5'd8,
        ALU_SRA    = 5'd13,
        ALU_PASS_B = 5'd15,
        ALU_MUL    = 5'd16,
        ALU_MULH   = 5'd17,
        ALU_MULHSU = 5'd18,
        ALU_MULHU  = 5'd19,
        ALU_DIV    = 5'd20,
        ALU_DIVU   = 5'd21,
        ALU_REM    = 5'd22,
        ALU_REMU   = 5'd23
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_src_e;

    typedef struct packed {
        logic                  valid;
        logic                  pc_rs1_sel;
        logic                  imm_rs2_sel;
        logic                  jump_branch_sel;
        alu_op_e               alu_op;
        logic                  mem_we;
        logic [2:0]            ls_ctrl;
        logic                  we;
        wb_src_e               wb_src;
        logic [REG_ADDR_W-1:0] rd;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_BUBBLE = '0;

    function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt);
        return alu_op_e'({1'b0, alt, f3});
    endfunction

endpackage

// File: rtl/pipelined_control_unit_if.sv
// Bus between the ID register / datapath muxes and the control unit.
interface pipelined_control_unit_if;
    import rv_ctrl_pkg::*;

    // An ID instruction is consumed at a clock edge when id_valid=1, stall=0 and
    // hazard_stall=0; with flush=1 it is consumed and discarded. hazard_stall=1 means
    // the ID side must present the same instruction again next cycle.
    logic                  id_valid;
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  stall;
    logic                  flush;

    logic [IMM_SEL_W-1:0]  id_imm_sel;
    logic                  hazard_stall;
    logic                  illegal_instr;
    logic                  ex_pc_rs1_sel;
    logic                  ex_imm_rs2_sel;
    logic                  ex_jump_branch_sel;
    logic [ALU_OP_W-1:0]   ex_alu_op;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  mem_write_enable;
    logic [2:0]            mem_store_ctrl;
    logic [2:0]            mem_load_ctrl;
    logic                  wb_regfile_write_enable;
    logic [1:0]            wb_reg_write_ctrl;
    logic [REG_ADDR_W-1:0] wb_rd;

    modport master (
        output id_valid, opcode, funct3, funct7, rd, rs1, rs2, stall, flush,
        input  id_imm_sel, hazard_stall, illegal_instr,
               ex_pc_rs1_sel, ex_imm_rs2_sel, ex_jump_branch_sel, ex_alu_op, ex_rd,
               mem_write_enable, mem_store_ctrl, mem_load_ctrl,
               wb_regfile_write_enable, wb_reg_write_ctrl, wb_rd
    );

    modport slave (
        input  id_valid, opcode, funct3, funct7, rd, rs1, rs2, stall, flush,
        output id_imm_sel, hazard_stall, illegal_instr,
               ex_pc_rs1_sel, ex_imm_rs2_sel, ex_jump_branch_sel, ex_alu_op, ex_rd,
               mem_write_enable, mem_store_ctrl, mem_load_ctrl,
               wb_regfile_write_enable, wb_reg_write_ctrl, wb_rd
    );

endinterface

// File: rtl/rv_decoder.sv
// Combinational RV32I decode of the ID instruction into a control bundle plus illegal flag.
// With RV_M_EXT_EN defined, OP/funct7=0000001 decodes the M-extension ops.
module rv_decoder
    import rv_ctrl_pkg::*;
(
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic [REG_ADDR_W-1:0] rd,
    output ctrl_bundle_t          ctrl,
    output imm_sel_e              imm_sel,
    output logic                  use_rs1,
    output logic                  use_rs2,
    output logic                  illegal
);

    logic writes;

    always_comb begin
        ctrl       = CTRL_BUBBLE;
        ctrl.valid = 1'b1;
        imm_sel    = IMM_NONE;
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;
        illegal    = 1'b0;
        writes     = 1'b0;

        case (opcode)
            OPC_OP_IMM: begin
                imm_sel          = IMM_I;
                use_rs1          = 1'b1;
                ctrl.imm_rs2_sel = 1'b1;
                writes           = 1'b1;
                ctrl.alu_op      = alu_from_funct3(funct3, 1'b0);
                // Only the shift-immediates carry funct7; the others use those bits as immediate.
                if (funct3 == 3'b001) begin
                    illegal = (funct7 != F7_BASE);
                end else if (funct3 == 3'b101) begin
                    if (funct7 == F7_ALT) ctrl.alu_op = ALU_SRA;
                    else                  illegal     = (funct7 != F7_BASE);
                end
            end
            OPC_OP: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                writes  = 1'b1;
                if (funct7 == F7_BASE)
                    ctrl.alu_op = alu_from_funct3(funct3, 1'b0);
                else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))
                    ctrl.alu_op = alu_from_funct3(funct3, 1'b1);
`ifdef RV_M_EXT_EN
                else if (funct7 == F7_MULDIV)
                    ctrl.alu_op = alu_op_e'({2'b10, funct3});
`endif
                else
                    illegal = 1'b1;
            end
            OPC_LOAD: begin
                imm_sel          = IMM_I;
                use_rs1          = 1'b1;
                ctrl.imm_rs2_sel = 1'b1;
                ctrl.ls_ctrl     = funct3;
                ctrl.wb_src      = WB_MEM;
                writes           = 1'b1;
            end
            OPC_STORE: begin
                imm_sel          = IMM_S;
                use_rs1          = 1'b1;
                use_rs2          = 1'b1;
                ctrl.imm_rs2_sel = 1'b1;
                ctrl.mem_we      = 1'b1;
                ctrl.ls_ctrl     = funct3;
            end
            OPC_BRANCH: begin
                imm_sel              = IMM_B;
                use_rs1              = 1'b1;
                use_rs2              = 1'b1;
                ctrl.jump_branch_sel = 1'b1;
                case (funct3[2:1])
                    2'b10:   ctrl.alu_op = ALU_SLT;
                    2'b11:   ctrl.alu_op = ALU_SLTU;
                    default: ctrl.alu_op = ALU_SUB;
                endcase
            end
            OPC_JAL: begin
                imm_sel              = IMM_J;
                ctrl.pc_rs1_sel      = 1'b1;
                ctrl.imm_rs2_sel     = 1'b1;
                ctrl.jump_branch_sel = 1'b1;
                ctrl.wb_src          = WB_PC4;
                writes               = 1'b1;
            end
            OPC_JALR: begin
                imm_sel              = IMM_I;
                use_rs1              = 1'b1;
                ctrl.imm_rs2_sel     = 1'b1;
                ctrl.jump_branch_sel = 1'b1;
                ctrl.wb_src          = WB_PC4;
                writes               = 1'b1;
            end
            OPC_LUI: begin
                imm_sel          = IMM_U;
                ctrl.imm_rs2_sel = 1'b1;
                ctrl.alu_op      = ALU_PASS_B;
                writes           = 1'b1;
            end
            OPC_AUIPC: begin
                imm_sel          = IMM_U;
                ctrl.pc_rs1_sel  = 1'b1;
                ctrl.imm_rs2_sel = 1'b1;
                writes           = 1'b1;
            end
            default: illegal = 1'b1;
        endcase

        // x0 is never written; rd is only meaningful for writing instructions.
        ctrl.we = writes && (rd != '0);
        ctrl.rd = writes ? rd : '0;

        if (illegal) begin
            ctrl    = CTRL_BUBBLE;
            imm_sel = IMM_NONE;
            use_rs1 = 1'b0;
            use_rs2 = 1'b0;
        end
    end

endmodule

// File: rtl/pipelined_control_unit.sv
// RV32I pipelined control unit: decodes ID and carries registered control through ID/EX, EX/MEM, MEM/WB,
// with load-use bubbles, flush and global stall. Optional macro RV_M_EXT_EN enables M-extension decode.
module pipelined_control_unit
    import rv_ctrl_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    pipelined_control_unit_if.slave  bus
);

    ctrl_bundle_t dec_ctrl;
    imm_sel_e     dec_imm_sel;
    logic         dec_use_rs1;
    logic         dec_use_rs2;
    logic         dec_illegal;

    ctrl_bundle_t id_ex_d,  id_ex_q;
    ctrl_bundle_t ex_mem_d, ex_mem_q;
    ctrl_bundle_t mem_wb_d, mem_wb_q;

    logic load_in_ex;
    logic hazard_raw;

    rv_decoder u_decoder (
        .opcode  (bus.opcode),
        .funct3  (bus.funct3),
        .funct7  (bus.funct7),
        .rd      (bus.rd),
        .ctrl    (dec_ctrl),
        .imm_sel (dec_imm_sel),
        .use_rs1 (dec_use_rs1),
        .use_rs2 (dec_use_rs2),
        .illegal (dec_illegal)
    );

    always_comb begin
        load_in_ex = id_ex_q.valid && (id_ex_q.wb_src == WB_MEM);
        hazard_raw = bus.id_valid && load_in_ex && (id_ex_q.rd != '0) &&
                     ((dec_use_rs1 && id_ex_q.rd == bus.rs1) ||
                      (dec_use_rs2 && id_ex_q.rd == bus.rs2));
    end

    always_comb begin
        id_ex_d  = id_ex_q;
        ex_mem_d = ex_mem_q;
        mem_wb_d = mem_wb_q;
        if (!bus.stall) begin
            mem_wb_d = ex_mem_q;
            ex_mem_d = id_ex_q;
            // Flush, load-use and an idle/illegal ID all collapse to a single bubble.
            if (bus.flush || hazard_raw || !bus.id_valid) id_ex_d = CTRL_BUBBLE;
            else                                          id_ex_d = dec_ctrl;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_ex_q  <= CTRL_BUBBLE;
            ex_mem_q <= CTRL_BUBBLE;
            mem_wb_q <= CTRL_BUBBLE;
        end else begin
            id_ex_q  <= id_ex_d;
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
        end
    end

    assign bus.id_imm_sel    = bus.id_valid ? dec_imm_sel : IMM_NONE;
    assign bus.illegal_instr = bus.id_valid && dec_illegal;
    assign bus.hazard_stall  = hazard_raw && !bus.flush;

    assign bus.ex_pc_rs1_sel      = id_ex_q.valid && id_ex_q.pc_rs1_sel;
    assign bus.ex_imm_rs2_sel     = id_ex_q.valid && id_ex_q.imm_rs2_sel;
    assign bus.ex_jump_branch_sel = id_ex_q.valid && id_ex_q.jump_branch_sel;
    assign bus.ex_alu_op          = id_ex_q.valid ? id_ex_q.alu_op : '0;
    assign bus.ex_rd              = id_ex_q.valid ? id_ex_q.rd : '0;

    assign bus.mem_write_enable = ex_mem_q.valid && ex_mem_q.mem_we;
    assign bus.mem_store_ctrl   = (ex_mem_q.valid && ex_mem_q.mem_we) ? ex_mem_q.ls_ctrl : '0;
    assign bus.mem_load_ctrl    = (ex_mem_q.valid && ex_mem_q.wb_src == WB_MEM) ? ex_mem_q.ls_ctrl : '0;

    assign bus.wb_regfile_write_enable = mem_wb_q.valid && mem_wb_q.we;
    assign bus.wb_reg_write_ctrl       = mem_wb_q.valid ? mem_wb_q.wb_src : '0;
    assign bus.wb_rd                   = mem_wb_q.valid ? mem_wb_q.rd : '0;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench for pipelined_control_unit; define RV_M_EXT_EN to match an M-extension build.
module tb_pipelined_control_unit;

    localparam logic [6:0] T_OP_IMM = 7'b0010011;
    localparam logic [6:0] T_OP     = 7'b0110011;
    localparam logic [6:0] T_LOAD   = 7'b0000011;
    localparam logic [6:0] T_STORE  = 7'b0100011;
    localparam logic [6:0] T_BRANCH = 7'b1100011;
    localparam logic [6:0] T_JAL    = 7'b1101111;
    localparam logic [6:0] T_LUI    = 7'b0110111;
    localparam logic [6:0] T_AUIPC  = 7'b0010111;
    localparam logic [6:0] T_F7_0   = 7'b0000000;
    localparam logic [6:0] T_F7_ALT = 7'b0100000;
    localparam logic [6:0] T_F7_M   = 7'b0000001;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    pipelined_control_unit_if bus ();

    pipelined_control_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [6:0] op, input int f3, input logic [6:0] f7,
                         input int rd, input int rs1, input int rs2);
        bus.id_valid = v;
        bus.opcode   = op;
        bus.funct3   = 3'(f3);
        bus.funct7   = f7;
        bus.rd       = 5'(rd);
        bus.rs1      = 5'(rs1);
        bus.rs2      = 5'(rs2);
    endtask

    task automatic idle();
        drive(1'b0, 7'd0, 0, T_F7_0, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset     = 1'b1;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ex_alu",  32'(bus.ex_alu_op), 0);
        chk("rst_ex_imm",  32'(bus.ex_imm_rs2_sel), 0);
        chk("rst_mem_we",  32'(bus.mem_write_enable), 0);
        chk("rst_wb_we",   32'(bus.wb_regfile_write_enable), 0);
        chk("rst_hazard",  32'(bus.hazard_stall), 0);
        chk("rst_illegal", 32'(bus.illegal_instr), 0);
        reset = 1'b0;

        // ADDI x1,x0,5
        step(); drive(1'b1, T_OP_IMM, 0, T_F7_0, 1, 0, 5); mid();
        chk("addi_imm_sel", 32'(bus.id_imm_sel), 1);
        chk("addi_illegal", 32'(bus.illegal_instr), 0);
        step(); idle(); mid();
        chk("addi_ex_imm", 32'(bus.ex_imm_rs2_sel), 1);
        chk("addi_ex_alu", 32'(bus.ex_alu_op), 0);
        chk("addi_ex_rd",  32'(bus.ex_rd), 1);
        chk("addi_ex_pc",  32'(bus.ex_pc_rs1_sel), 0);
        step(); mid();
        chk("addi_mem_we", 32'(bus.mem_write_enable), 0);
        chk("addi_wb_early", 32'(bus.wb_regfile_write_enable), 0);
        step(); mid();
        chk("addi_wb_we",   32'(bus.wb_regfile_write_enable), 1);
        chk("addi_wb_ctrl", 32'(bus.wb_reg_write_ctrl), 0);
        chk("addi_wb_rd",   32'(bus.wb_rd), 1);

        // LW x5,0(x2) then ADD x6,x5,x7
        step(); drive(1'b1, T_LOAD, 2, T_F7_0, 5, 2, 0); mid();
        chk("lw_imm_sel", 32'(bus.id_imm_sel), 1);
        chk("lw_no_hazard", 32'(bus.hazard_stall), 0);
        step(); drive(1'b1, T_OP, 0, T_F7_0, 6, 5, 7); mid();
        chk("lu_hazard", 32'(bus.hazard_stall), 1);
        chk("lu_ex_rd",  32'(bus.ex_rd), 5);
        step(); mid();
        chk("lu_hazard_once", 32'(bus.hazard_stall), 0);
        chk("lu_bubble_imm",  32'(bus.ex_imm_rs2_sel), 0);
        chk("lu_bubble_rd",   32'(bus.ex_rd), 0);
        chk("lu_mem_load",    32'(bus.mem_load_ctrl), 2);
        step(); idle(); mid();
        chk("lu_add_ex_rd",  32'(bus.ex_rd), 6);
        chk("lu_add_ex_alu", 32'(bus.ex_alu_op), 0);
        chk("lu_lw_wb_ctrl", 32'(bus.wb_reg_write_ctrl), 1);
        chk("lu_lw_wb_rd",   32'(bus.wb_rd), 5);

        // LW x5; LUI x9 (rs fields alias x5, unused); LW x5; SW x5 via rs2
        step(); drive(1'b1, T_LOAD, 2, T_F7_0, 5, 2, 0); mid();
        step(); drive(1'b1, T_LUI, 0, T_F7_0, 9, 5, 5); mid();
        chk("lui_no_hazard", 32'(bus.hazard_stall), 0);
        chk("lui_imm_sel",   32'(bus.id_imm_sel), 4);
        step(); drive(1'b1, T_LOAD, 2, T_F7_0, 5, 2, 0); mid();
        chk("lui_ex_alu", 32'(bus.ex_alu_op), 15);
        chk("lui_ex_rd",  32'(bus.ex_rd), 9);
        step(); drive(1'b1, T_STORE, 2, T_F7_0, 0, 2, 5); mid();
        chk("sw_rs2_hazard", 32'(bus.hazard_stall), 1);
        step(); idle(); mid();
        repeat (3) step();

        // JAL x1 in EX with flush
        step(); drive(1'b1, T_JAL, 0, T_F7_0, 1, 0, 0); mid();
        chk("jal_imm_sel", 32'(bus.id_imm_sel), 5);
        step(); drive(1'b1, T_OP, 0, T_F7_0, 6, 5, 7); bus.flush = 1'b1; mid();
        chk("jal_ex_jb", 32'(bus.ex_jump_branch_sel), 1);
        chk("jal_ex_pc", 32'(bus.ex_pc_rs1_sel), 1);
        chk("jal_flush_hazard", 32'(bus.hazard_stall), 0);
        step(); bus.flush = 1'b0; idle(); mid();
        chk("jal_flush_ex_rd", 32'(bus.ex_rd), 0);
        chk("jal_flush_ex_jb", 32'(bus.ex_jump_branch_sel), 0);
        step(); mid();
        chk("jal_wb_ctrl", 32'(bus.wb_reg_write_ctrl), 2);
        chk("jal_wb_we",   32'(bus.wb_regfile_write_enable), 1);
        chk("jal_wb_rd",   32'(bus.wb_rd), 1);

        // Flush coincident with a load-use hazard
        step(); drive(1'b1, T_LOAD, 2, T_F7_0, 5, 2, 0); mid();
        step(); drive(1'b1, T_OP, 0, T_F7_0, 6, 5, 7); bus.flush = 1'b1; mid();
        chk("fh_hazard_masked", 32'(bus.hazard_stall), 0);
        step(); bus.flush = 1'b0; idle(); mid();
        chk("fh_bubble_rd",  32'(bus.ex_rd), 0);
        chk("fh_mem_load",   32'(bus.mem_load_ctrl), 2);
        step(); mid();
        chk("fh_no_add_rd",  32'(bus.ex_rd), 0);
        chk("fh_wb_rd",      32'(bus.wb_rd), 5);
        repeat (2) step();

        // SW x7,8(x2) held by a 3-cycle stall
        step(); drive(1'b1, T_STORE, 2, T_F7_0, 8, 2, 7); mid();
        chk("sw_imm_sel", 32'(bus.id_imm_sel), 2);
        step(); idle(); bus.stall = 1'b1; mid();
        chk("sw_ex_imm", 32'(bus.ex_imm_rs2_sel), 1);
        chk("sw_ex_rd",  32'(bus.ex_rd), 0);
        step(); mid();
        chk("stall1_ex_imm", 32'(bus.ex_imm_rs2_sel), 1);
        chk("stall1_mem_we", 32'(bus.mem_write_enable), 0);
        step(); mid();
        chk("stall2_ex_imm", 32'(bus.ex_imm_rs2_sel), 1);
        chk("stall2_mem_we", 32'(bus.mem_write_enable), 0);
        step(); bus.stall = 1'b0; mid();
        chk("release_ex_imm", 32'(bus.ex_imm_rs2_sel), 1);
        chk("release_mem_we", 32'(bus.mem_write_enable), 0);
        step(); mid();
        chk("sw_mem_we",    32'(bus.mem_write_enable), 1);
        chk("sw_mem_ctrl",  32'(bus.mem_store_ctrl), 2);
        chk("sw_ex_left",   32'(bus.ex_imm_rs2_sel), 0);
        repeat (2) step();

        // Illegal opcode, ADD x0, SUB, bad OP funct7, SRAI, BLT
        step(); drive(1'b1, 7'b0000000, 0, T_F7_0, 3, 1, 2); mid();
        chk("ill_op_flag",    32'(bus.illegal_instr), 1);
        chk("ill_op_imm_sel", 32'(bus.id_imm_sel), 0);
        step(); drive(1'b1, T_OP, 0, T_F7_0, 0, 1, 2); mid();
        chk("add_x0_legal",  32'(bus.illegal_instr), 0);
        chk("ill_bubble_rd", 32'(bus.ex_rd), 0);
        chk("ill_bubble_ex", 32'(bus.ex_imm_rs2_sel), 0);
        step(); drive(1'b1, T_OP, 0, T_F7_ALT, 4, 1, 2); mid();
        chk("add_x0_ex_rd", 32'(bus.ex_rd), 0);
        step(); drive(1'b1, T_OP, 1, T_F7_ALT, 4, 1, 2); mid();
        chk("bad_f7_flag", 32'(bus.illegal_instr), 1);
        chk("sub_ex_alu",  32'(bus.ex_alu_op), 8);
        chk("sub_ex_rd",   32'(bus.ex_rd), 4);
        step(); drive(1'b1, T_OP_IMM, 5, T_F7_ALT, 7, 1, 3); mid();
        chk("srai_legal",    32'(bus.illegal_instr), 0);
        chk("bad_f7_bubble", 32'(bus.ex_rd), 0);
        chk("add_x0_wb_we",  32'(bus.wb_regfile_write_enable), 0);
        step(); drive(1'b1, T_BRANCH, 4, T_F7_0, 0, 1, 2); mid();
        chk("blt_imm_sel", 32'(bus.id_imm_sel), 3);
        chk("srai_ex_alu", 32'(bus.ex_alu_op), 13);
        chk("sub_wb_we",   32'(bus.wb_regfile_write_enable), 1);
        chk("sub_wb_rd",   32'(bus.wb_rd), 4);
        step(); idle(); mid();
        chk("blt_ex_alu", 32'(bus.ex_alu_op), 2);
        chk("blt_ex_jb",  32'(bus.ex_jump_branch_sel), 1);
        chk("blt_ex_imm", 32'(bus.ex_imm_rs2_sel), 0);

        // MUL x3,x1,x2
        step(); drive(1'b1, T_OP, 0, T_F7_M, 3, 1, 2); mid();
`ifdef RV_M_EXT_EN
        chk("mul_illegal", 32'(bus.illegal_instr), 0);
`else
        chk("mul_illegal", 32'(bus.illegal_instr), 1);
`endif
        step(); idle(); mid();
`ifdef RV_M_EXT_EN
        chk("mul_ex_alu", 32'(bus.ex_alu_op), 16);
        chk("mul_ex_rd",  32'(bus.ex_rd), 3);
`else
        chk("mul_ex_alu", 32'(bus.ex_alu_op), 0);
        chk("mul_ex_rd",  32'(bus.ex_rd), 0);
`endif

        // Fill the pipeline, then reset asynchronously mid-cycle
        step(); drive(1'b1, T_OP_IMM, 0, T_F7_0, 1, 0, 5);
        step(); drive(1'b1, T_LUI, 0, T_F7_0, 2, 0, 0);
        step(); drive(1'b1, T_AUIPC, 0, T_F7_0, 3, 0, 0);
        step(); idle();
        chk("pre_rst_wb_we", 32'(bus.wb_regfile_write_enable), 1);
        chk("pre_rst_ex_pc", 32'(bus.ex_pc_rs1_sel), 1);
        #1 reset = 1'b1;
        #1;
        chk("arst_wb_we",  32'(bus.wb_regfile_write_enable), 0);
        chk("arst_wb_rd",  32'(bus.wb_rd), 0);
        chk("arst_ex_pc",  32'(bus.ex_pc_rs1_sel), 0);
        chk("arst_ex_imm", 32'(bus.ex_imm_rs2_sel), 0);
        chk("arst_ex_rd",  32'(bus.ex_rd), 0);
        chk("arst_ex_alu", 32'(bus.ex_alu_op), 0);
        step(); reset = 1'b0;
        repeat (2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
